// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit display scan controller.
package digit_scan_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Counter width able to hold 0 .. max(a,b)-1, never narrower than one bit.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_scan_timer.sv
// Reloadable up-counter; o_tc flags the cycle where the count equals i_lim.
module scan_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic [CW-1:0] i_lim,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) r_cnt <= '0;
    else                r_cnt <= r_cnt + CW'(1);
  end

  assign o_tc = (r_cnt == i_lim);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scan controller: blank gap, then capture and light one digit, cycling sel 0..3.
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 8,
  parameter int BLANK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       mask,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       an,
  output logic             frame
);

  localparam int CW = cnt_w(DWELL, BLANK);
  localparam logic [CW-1:0] LIM_BLANK = CW'(BLANK - 1);
  localparam logic [CW-1:0] LIM_DWELL = CW'(DWELL - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [WIDTH-1:0] r_y, w_y_nxt, w_dsel;
  logic [3:0]       r_an, w_an_nxt;
  logic             r_frame, w_frame_nxt;
  logic             w_clr, w_tc;
  logic [CW-1:0]    w_lim;

  scan_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_lim (w_lim),
    .o_tc  (w_tc)
  );

  always_comb begin
    case (r_sel)
      2'd0:    w_dsel = d0;
      2'd1:    w_dsel = d1;
      2'd2:    w_dsel = d2;
      default: w_dsel = d3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
      r_y     <= '0;
      r_an    <= AN_OFF;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_y     <= w_y_nxt;
      r_an    <= w_an_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // The timer is cleared on every interval boundary and held at zero in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_y_nxt     = r_y;
    w_an_nxt    = r_an;
    w_frame_nxt = 1'b0;
    w_clr       = 1'b0;
    w_lim       = LIM_DWELL;
    case (r_state)
      ST_IDLE: begin
        w_clr    = 1'b1;
        w_an_nxt = AN_OFF;
        if (en) begin
          w_state_nxt = ST_BLANK;
          w_sel_nxt   = 2'd0;
        end
      end
      ST_BLANK: begin
        w_lim = LIM_BLANK;
        if (w_tc) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_SHOW;
          w_y_nxt     = w_dsel;
          w_an_nxt    = mask[r_sel] ? AN_OFF : ~(4'b0001 << r_sel);
        end
      end
      ST_SHOW: begin
        if (w_tc) begin
          w_clr       = 1'b1;
          w_an_nxt    = AN_OFF;
          w_sel_nxt   = r_sel + 2'd1;
          w_frame_nxt = (r_sel == 2'd3);
          w_state_nxt = en ? ST_BLANK : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sel   = r_sel;
  assign y     = r_y;
  assign an    = r_an;
  assign frame = r_frame;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: directed table, corner sequences, random run vs slot-arithmetic model.
module tb_digit_scan_ctrl;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int BL = 2;
  localparam int P  = BL + DW;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic [W-1:0] d0 = 4'd1, d1 = 4'd2, d2 = 4'd3, d3 = 4'd4;
  logic [3:0]   mask = 4'b0000;
  logic [1:0]   sel;
  logic [W-1:0] y;
  logic [3:0]   an;
  logic         frame;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  digit_scan_ctrl #(.WIDTH(W), .DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .reset(reset), .en(en),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .mask(mask),
    .sel(sel), .y(y), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] a, input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (an !== a && k < budget);
    check("wait_an_timeout", {28'd0, an}, {28'd0, a});
  endtask

  // Reference model: a running scan is a position counter; digit and slot phase
  // come from division by the slot length, and en is only honoured at slot end.
  bit           m_act = 1'b0;
  int           m_pos = 0;
  logic [1:0]   m_sel = 2'd0;
  logic [W-1:0] m_y = '0;
  logic [3:0]   m_an = 4'hF;
  logic         m_fr = 1'b0;

  function automatic logic [W-1:0] dpick(input int i);
    case (i)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  always @(posedge clk) begin
    int slot, dig;
    logic [3:0] one;
    one = 4'b0001;
    if (reset) begin
      m_act = 1'b0; m_sel = 2'd0; m_y = '0; m_an = 4'hF; m_fr = 1'b0;
    end else begin
      m_fr = 1'b0;
      if (!m_act) begin
        m_an = 4'hF;
        if (en) begin m_act = 1'b1; m_pos = 0; m_sel = 2'd0; end
      end else begin
        slot = m_pos % P;
        dig  = (m_pos / P) % 4;
        if (slot == BL - 1) begin
          m_y  = dpick(dig);
          m_an = mask[dig] ? 4'hF : ~(one << dig);
        end
        if (slot == P - 1) begin
          m_an  = 4'hF;
          m_sel = 2'((dig + 1) % 4);
          m_fr  = (dig == 3);
          if (en) m_pos++;
          else    m_act = 1'b0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mon_sel", {30'd0, sel}, {30'd0, m_sel});
      check("mon_y", {28'd0, y}, {28'd0, m_y});
      check("mon_an", {28'd0, an}, {28'd0, m_an});
      check("mon_frame", {31'd0, frame}, {31'd0, m_fr});
      check("mon_an_onehot", {31'd0, ($countones(~an) > 1)}, 32'd0);
    end
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] mask;
    int         n;
    logic [3:0] an;
    logic [3:0] y;
    logic [1:0] sel;
    logic       fr;
  } vec_t;

  vec_t tv[$];

  initial begin
    int cnt, fcnt;
    int ft[$];

    // Full frame with defaults, then a frame with digit 2 masked.
    tv.push_back('{1'b1, 1'b1, 4'h0, 1, 4'hF, 4'd0, 2'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 2, 4'hF, 4'd0, 2'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 8, 4'hE, 4'd1, 2'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 2, 4'hF, 4'd1, 2'd1, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 8, 4'hD, 4'd2, 2'd1, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 2, 4'hF, 4'd2, 2'd2, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 8, 4'hB, 4'd3, 2'd2, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 2, 4'hF, 4'd3, 2'd3, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h0, 8, 4'h7, 4'd4, 2'd3, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 1, 4'hF, 4'd4, 2'd0, 1'b1});
    tv.push_back('{1'b0, 1'b1, 4'h4, 1, 4'hF, 4'd4, 2'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 8, 4'hE, 4'd1, 2'd0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 2, 4'hF, 4'd1, 2'd1, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 8, 4'hD, 4'd2, 2'd1, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 2, 4'hF, 4'd2, 2'd2, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 8, 4'hF, 4'd3, 2'd2, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 2, 4'hF, 4'd3, 2'd3, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 8, 4'h7, 4'd4, 2'd3, 1'b0});
    tv.push_back('{1'b0, 1'b1, 4'h4, 1, 4'hF, 4'd4, 2'd0, 1'b1});

    reset = 1'b1; en = 1'b0;
    step(); step();
    chk_on = 1'b1;

    foreach (tv[i]) begin
      for (int c = 0; c < tv[i].n; c++) begin
        reset = tv[i].rst; en = tv[i].en; mask = tv[i].mask;
        step();
        check($sformatf("tbl%0d_an", i), {28'd0, an}, {28'd0, tv[i].an});
        check($sformatf("tbl%0d_y", i), {28'd0, y}, {28'd0, tv[i].y});
        check($sformatf("tbl%0d_sel", i), {30'd0, sel}, {30'd0, tv[i].sel});
        check($sformatf("tbl%0d_frame", i), {31'd0, frame}, {31'd0, tv[i].fr});
      end
    end
    mask = 4'h0;

    // d1 changes mid-SHOW of digit 1: held until next capture.
    wait_an(4'hD, 60);
    step(); step(); step();
    d1 = 4'd9;
    cnt = 0;
    while (an === 4'hD && cnt < 12) begin
      check("t3_y_held", {28'd0, y}, 32'd2);
      step();
      cnt++;
    end
    wait_an(4'hD, 60);
    check("t3_y_new", {28'd0, y}, 32'd9);

    // en dropped mid-SHOW of digit 2: digit completes, then IDLE.
    wait_an(4'hB, 60);
    cnt = 1;
    step(); cnt++;
    en = 1'b0;
    step(); cnt++;
    while (an === 4'hB && cnt < 20) begin step(); cnt++; end
    check("t4_show_len", cnt - 1, DW);
    for (int k = 0; k < 4; k++) begin
      check("t4_idle_an", {28'd0, an}, 32'hF);
      check("t4_idle_frame", {31'd0, frame}, 32'd0);
      check("t4_idle_sel", {30'd0, sel}, 32'd3);
      step();
    end
    en = 1'b1;
    step();
    check("t4_restart_sel", {30'd0, sel}, 32'd0);
    check("t4_restart_an0", {28'd0, an}, 32'hF);
    step();
    check("t4_restart_an1", {28'd0, an}, 32'hF);
    step();
    check("t4_restart_lit", {28'd0, an}, 32'hE);

    // Reset during SHOW of digit 3.
    wait_an(4'h7, 60);
    step(); step(); step();
    reset = 1'b1;
    step();
    check("t5_an", {28'd0, an}, 32'hF);
    check("t5_sel", {30'd0, sel}, 32'd0);
    check("t5_y", {28'd0, y}, 32'd0);
    check("t5_frame", {31'd0, frame}, 32'd0);
    step();
    reset = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_idle_an", {28'd0, an}, 32'hF);
    end

    // Continuous run: three frame pulses exactly one period apart.
    en = 1'b1;
    for (int k = 1; k <= 4 * P * 3 + 5; k++) begin
      step();
      if (frame === 1'b1) ft.push_back(k);
    end
    fcnt = ft.size();
    check("t6_frame_count", fcnt, 3);
    if (fcnt == 3) begin
      check("t6_first_frame", ft[0], 4 * P + 1);
      check("t6_period_a", ft[1] - ft[0], 4 * P);
      check("t6_period_b", ft[2] - ft[1], 4 * P);
    end

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) begin
        d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) mask = 4'($urandom);
      step();
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
